// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache: FSM encoding and a
// ceil-log2 helper used to size address fields.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WORD_W = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Cache data array: one 32-bit word per entry, asynchronous read and
// byte-strobed synchronous write through a single shared address.
module dcache_line_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    strobe,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through L1 data cache with burst refill and flush.
// Define DCACHE_PERF_COUNTERS_EN to add saturating hit/miss counter outputs.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  read_request,
    input  logic                  write_request,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    output logic                  response,
    output logic [31:0]           read_data,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    input  logic                  memory_response,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [31:0]           memory_write_data,
    output logic [3:0]            memory_write_strobe,
    input  logic [31:0]           memory_read_data,
`ifdef DCACHE_PERF_COUNTERS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    output state_t                dbg_state
);

    localparam int OFFSET_BITS = clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS  = clog2(NUM_LINES);
    localparam int TAG_BITS    = ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;
    localparam int RAM_AW      = OFFSET_BITS + INDEX_BITS;
    localparam int CNT_W       = (OFFSET_BITS == 0) ? 1 : OFFSET_BITS;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);

    state_t state, next_state;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags [NUM_LINES];
    logic [CNT_W-1:0]     refill_count;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [RAM_AW-1:0]     word_idx;
    logic [RAM_AW-1:0]     refill_idx;
    logic                  hit;
    logic                  refill_last;

    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_strobe;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    assign idx         = addr[2+OFFSET_BITS +: INDEX_BITS];
    assign tag         = addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign word_idx    = addr[2 +: RAM_AW];
    assign refill_idx  = (word_idx & ~RAM_AW'(WORDS_PER_LINE - 1)) | RAM_AW'(refill_count);
    assign hit         = valid[idx] && (tags[idx] == tag);
    assign refill_last = (refill_count == CNT_W'(WORDS_PER_LINE - 1));
    assign dbg_state   = state;

    dcache_line_ram #(
        .DEPTH (NUM_LINES * WORDS_PER_LINE),
        .AW    (RAM_AW)
    ) u_line_ram (
        .clk    (clk),
        .addr   (ram_addr),
        .strobe (ram_strobe),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    // Handshake: core requests are held until a one-cycle response; bus
    // requests are held until a one-cycle memory_response, which completes one word.
    always_comb begin
        next_state           = state;
        response             = 1'b0;
        read_data            = '0;
        memory_read_request  = 1'b0;
        memory_write_request = 1'b0;
        memory_addr          = '0;
        memory_write_data    = '0;
        memory_write_strobe  = '0;
        ram_addr             = word_idx;
        ram_strobe           = '0;
        ram_wdata            = write_data;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (write_request) begin
                        if (hit) ram_strobe = write_strobe;
                        next_state = WRITE;
                    end else if (read_request) begin
                        if (hit) begin
                            response  = 1'b1;
                            read_data = ram_rdata;
                        end else begin
                            next_state = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                memory_read_request = 1'b1;
                memory_addr         = (addr & LINE_MASK) | (ADDR_WIDTH'(refill_count) << 2);
                ram_addr            = refill_idx;
                if (memory_response) begin
                    ram_strobe = 4'hF;
                    ram_wdata  = memory_read_data;
                    if (refill_last) next_state = DONE;
                end
            end
            WRITE: begin
                memory_write_request = 1'b1;
                memory_addr          = addr & ~ADDR_WIDTH'(3);
                memory_write_data    = write_data;
                memory_write_strobe  = write_strobe;
                if (memory_response) next_state = DONE;
            end
            DONE: begin
                response   = 1'b1;
                if (!write_request) read_data = ram_rdata;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            valid        <= '0;
            refill_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && flush) valid <= '0;
            // The victim line is invalid while its words are being replaced.
            if (state == IDLE && next_state == REFILL) begin
                refill_count <= '0;
                valid[idx]   <= 1'b0;
            end
            if (state == REFILL && memory_response) begin
                refill_count <= refill_last ? '0 : refill_count + CNT_W'(1);
                if (refill_last) valid[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state == REFILL && memory_response && refill_last) tags[idx] <= tag;
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic hit_event;
    logic miss_event;

    assign hit_event  = (state == IDLE) && !flush && read_request && !write_request && hit;
    assign miss_event = (state == IDLE) && (next_state == REFILL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_event && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            if (miss_event && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: table of load/store vectors against a
// behavioural word-bus memory, plus flush, stray-response and reset-abort sequences.
module tb_dcache_wt;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        read_request = 1'b0;
    logic        write_request = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_strobe = '0;
    logic        response;
    logic [31:0] read_data;
    logic        memory_read_request;
    logic        memory_write_request;
    logic        memory_response;
    logic [31:0] memory_addr;
    logic [31:0] memory_write_data;
    logic [3:0]  memory_write_strobe;
    logic [31:0] memory_read_data = '0;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif
    state_t      dbg_state;

    logic bus_resp = 1'b0;
    logic stray_resp = 1'b0;
    assign memory_response = bus_resp | stray_resp;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dcache_wt #(
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4),
        .ADDR_WIDTH     (32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .read_request         (read_request),
        .write_request        (write_request),
        .addr                 (addr),
        .write_data           (write_data),
        .write_strobe         (write_strobe),
        .response             (response),
        .read_data            (read_data),
        .memory_read_request  (memory_read_request),
        .memory_write_request (memory_write_request),
        .memory_response      (memory_response),
        .memory_addr          (memory_addr),
        .memory_write_data    (memory_write_data),
        .memory_write_strobe  (memory_write_strobe),
        .memory_read_data     (memory_read_data),
`ifdef DCACHE_PERF_COUNTERS_EN
        .hit_count            (hit_count),
        .miss_count           (miss_count),
`endif
        .dbg_state            (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- bus memory model ----------------
    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } bus_t;

    bus_t        bus_log[$];
    logic [31:0] mem_model [logic [31:0]];
    int          bus_lat = 2;
    int          wait_cnt = 0;
    int          both_viol = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(negedge clk) begin
        bus_t        e;
        logic [31:0] w;
        bus_resp = 1'b0;
        if (memory_read_request && memory_write_request) both_viol++;
        if (memory_read_request || memory_write_request) begin
            wait_cnt++;
            if (wait_cnt >= bus_lat) begin
                wait_cnt = 0;
                bus_resp = 1'b1;
                e.w = memory_write_request;
                e.a = memory_addr;
                e.s = memory_write_strobe;
                if (memory_write_request) begin
                    w = mem_rd(memory_addr);
                    for (int b = 0; b < 4; b++)
                        if (memory_write_strobe[b]) w[8*b +: 8] = memory_write_data[8*b +: 8];
                    mem_model[memory_addr] = w;
                    e.d = memory_write_data;
                end else begin
                    memory_read_data = mem_rd(memory_addr);
                    e.d = memory_read_data;
                end
                bus_log.push_back(e);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rdat, output int lat);
        @(negedge clk);
        read_request  = rd;
        write_request = wr;
        addr          = a;
        write_data    = wd;
        write_strobe  = st;
        #1;
        lat = 0;
        while (!response && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!response) begin
            total++;
            bad++;
            $display("FAIL timeout addr=%h actual=no_response required=response", a);
        end
        rdat = read_data;
        @(negedge clk);
        read_request  = 1'b0;
        write_request = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          blat;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_nbus;
    } vec_t;

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] st, input int blat, input logic [31:0] exp_rd,
                                input int exp_lat, input int exp_nbus);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.st = st; v.blat = blat;
        v.exp_rd = exp_rd; v.exp_lat = exp_lat; v.exp_nbus = exp_nbus;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] rdat;
        int          lat;
        int          start;
        int          nb;
        int          exp_hits;
        int          exp_misses;
        bus_t        e;

        //          rd wr addr          wdata         strb   blat exp_rd        lat nbus
        vecs.push_back(mk(1, 0, 32'h0000_0100, 32'h0,         4'h0,  2, 32'hA5A5_0100, 9, 4));
        vecs.push_back(mk(1, 0, 32'h0000_0108, 32'h0,         4'h0,  2, 32'hA5A5_0108, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0104, 32'hAABB_CCDD, 4'h3,  2, 32'h0,         3, 1));
        vecs.push_back(mk(1, 0, 32'h0000_0104, 32'h0,         4'h0,  2, 32'hA5A5_CCDD, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0400, 32'h1234_5678, 4'hF,  2, 32'h0,         3, 1));
        vecs.push_back(mk(1, 0, 32'h0000_0400, 32'h0,         4'h0,  2, 32'h1234_5678, 9, 4));
        vecs.push_back(mk(1, 0, 32'h0000_040C, 32'h0,         4'h0,  2, 32'hA5A5_040C, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0104, 32'h0,         4'h0,  2, 32'hA5A5_CCDD, 9, 4));
        vecs.push_back(mk(1, 0, 32'h0000_0400, 32'h0,         4'h0,  2, 32'h1234_5678, 9, 4));
        vecs.push_back(mk(1, 0, 32'h0000_00F8, 32'h0,         4'h0,  1, 32'hA5A5_00F8, 5, 4));
        vecs.push_back(mk(1, 0, 32'h0000_00F4, 32'h0,         4'h0,  1, 32'hA5A5_00F4, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0200, 32'h1122_3344, 4'hC,  3, 32'h0,         4, 1));
        vecs.push_back(mk(1, 0, 32'h0000_0400, 32'h0,         4'h0,  2, 32'h1234_5678, 0, 0));
        vecs.push_back(mk(1, 1, 32'h0000_0408, 32'hCAFE_F00D, 4'hF,  2, 32'h0,         3, 1));
        vecs.push_back(mk(1, 0, 32'h0000_0408, 32'h0,         4'h0,  2, 32'hCAFE_F00D, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0000_0208, 32'h0,         4'h0,  1, 32'hA5A5_0208, 5, 4));
        vecs.push_back(mk(1, 0, 32'h0000_0200, 32'h0,         4'h0,  1, 32'h1122_0200, 0, 0));

        // ---------------- reset ----------------
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_response", 32'(response), 32'h0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_mem_rd_req", 32'(memory_read_request), 32'h0);
        check("rst_mem_wr_req", 32'(memory_write_request), 32'h0);
        check("rst_mem_addr", memory_addr, 32'h0);
        check("rst_mem_wdata", memory_write_data, 32'h0);
        check("rst_mem_strobe", 32'(memory_write_strobe), 32'h0);
`ifdef DCACHE_PERF_COUNTERS_EN
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        reset = 1'b1;

        // ---------------- table ----------------
        exp_hits   = 0;
        exp_misses = 0;
        foreach (vecs[i]) begin
            bus_lat = vecs[i].blat;
            start   = bus_log.size();
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st, rdat, lat);
            nb = bus_log.size() - start;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_bus_count", i), 32'(nb), 32'(vecs[i].exp_nbus));
            if (vecs[i].rd && !vecs[i].wr) begin
                check($sformatf("v%0d_read_data", i), rdat, vecs[i].exp_rd);
                if (vecs[i].exp_nbus == 0) exp_hits++;
                else exp_misses++;
            end
            for (int k = 0; k < nb; k++) begin
                e = bus_log[start + k];
                if (vecs[i].wr) begin
                    check($sformatf("v%0d_bus_is_write", i), 32'(e.w), 32'h1);
                    check($sformatf("v%0d_bus_waddr", i), e.a, vecs[i].a & ~32'h3);
                    check($sformatf("v%0d_bus_wdata", i), e.d, vecs[i].wd);
                    check($sformatf("v%0d_bus_wstrobe", i), 32'(e.s), 32'(vecs[i].st));
                end else begin
                    check($sformatf("v%0d_bus_is_read", i), 32'(e.w), 32'h0);
                    check($sformatf("v%0d_bus_raddr%0d", i, k), e.a, (vecs[i].a & 32'hFFFF_FFF0) + 32'(4 * k));
                end
            end
        end

        // ---------------- flush with a same-cycle read ----------------
        bus_lat = 2;
        @(negedge clk);
        flush         = 1'b1;
        read_request  = 1'b1;
        addr          = 32'h0000_0408;
        #1;
        check("flush_blocks_hit", 32'(response), 32'h0);
        @(negedge clk);
        flush        = 1'b0;
        read_request = 1'b0;
        #1;
        check("flush_state", 32'(dbg_state), 32'(IDLE));
        start = bus_log.size();
        access(1, 0, 32'h0000_0408, 32'h0, 4'h0, rdat, lat);
        exp_misses++;
        check("flush_refill_latency", 32'(lat), 32'd9);
        check("flush_refill_bus", 32'(bus_log.size() - start), 32'd4);
        check("flush_refill_data", rdat, 32'hCAFE_F00D);
        check("flush_refill_first", bus_log[start].a, 32'h0000_0400);

        // ---------------- stray bus response in IDLE ----------------
        @(negedge clk);
        stray_resp = 1'b1;
        #1;
        check("stray_response", 32'(response), 32'h0);
        @(negedge clk);
        stray_resp = 1'b0;
        #1;
        check("stray_state", 32'(dbg_state), 32'(IDLE));
        start = bus_log.size();
        access(1, 0, 32'h0000_0404, 32'h0, 4'h0, rdat, lat);
        exp_hits++;
        check("stray_hit_latency", 32'(lat), 32'd0);
        check("stray_hit_data", rdat, 32'hA5A5_0404);
        check("stray_hit_bus", 32'(bus_log.size() - start), 32'd0);

`ifdef DCACHE_PERF_COUNTERS_EN
        check("perf_hits", hit_count, 32'(exp_hits));
        check("perf_misses", miss_count, 32'(exp_misses));
`endif

        // ---------------- reset during the second refill word ----------------
        bus_lat = 2;
        start   = bus_log.size();
        @(negedge clk);
        read_request = 1'b1;
        addr         = 32'h0000_0100;
        #1;
        for (int c = 0; c < 50 && bus_log.size() == start; c++) begin
            @(negedge clk);
            #1;
        end
        check("abort_first_word", 32'(bus_log.size() - start), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_req_held", 32'(memory_read_request), 32'h1);
        @(negedge clk);
        read_request = 1'b0;
        #1;
        check("abort_req_dropped", 32'(memory_read_request), 32'h0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        check("abort_bus_count", 32'(bus_log.size() - start), 32'd1);
`ifdef DCACHE_PERF_COUNTERS_EN
        check("abort_hit_count", hit_count, 32'h0);
        check("abort_miss_count", miss_count, 32'h0);
`endif
        reset = 1'b1;
        start = bus_log.size();
        access(1, 0, 32'h0000_0100, 32'h0, 4'h0, rdat, lat);
        check("restart_latency", 32'(lat), 32'd9);
        check("restart_bus", 32'(bus_log.size() - start), 32'd4);
        check("restart_first", bus_log[start].a, 32'h0000_0100);
        check("restart_last", bus_log[bus_log.size() - 1].a, 32'h0000_010C);
        check("restart_data", rdat, 32'hA5A5_0100);
`ifdef DCACHE_PERF_COUNTERS_EN
        check("restart_miss_count", miss_count, 32'h1);
        check("restart_hit_count", hit_count, 32'h0);
`endif

        check("bus_rd_wr_overlap", 32'(both_viol), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
